// File: rtl/jvo_pulse_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : jvo_pulse_seq_if
// Brief    : Register-side bundle for the N-channel pulse sequencer. The
//            register file is the master, the sequencer is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface jvo_pulse_seq_if #(
  parameter int N_CH  = 20,
  parameter int CNT_W = 32,
  parameter int REP_W = 16
);
  logic                    i_en;
  logic                    i_run;
  logic                    i_single;
  logic [REP_W-1:0]        i_rep_count;
  logic [CNT_W-1:0]        i_max_count;
  logic [N_CH*CNT_W-1:0]   i_cnt_beg;
  logic [N_CH*CNT_W-1:0]   i_cnt_end;
  logic [N_CH-1:0]         i_io_init;
  logic                    i_upd;
  logic [N_CH-1:0]         o_io;
  logic [CNT_W-1:0]        o_count;
  logic                    o_period_tick;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_upd_ack;

  modport master (
    output i_en, i_run, i_single, i_rep_count, i_max_count,
           i_cnt_beg, i_cnt_end, i_io_init, i_upd,
    input  o_io, o_count, o_period_tick, o_busy, o_done, o_upd_ack
  );

  modport slave (
    input  i_en, i_run, i_single, i_rep_count, i_max_count,
           i_cnt_beg, i_cnt_end, i_io_init, i_upd,
    output o_io, o_count, o_period_tick, o_busy, o_done, o_upd_ack
  );
endinterface
`default_nettype wire

// File: rtl/jvo_pulse_seq.sv
`default_nettype none
// ============================================================================
// Module   : jvo_pulse_seq
// Brief    : N-channel pulse sequencer. One period counter drives per-channel
//            begin/end compares; settings are double-buffered and only change
//            at period boundaries while running. Single-shot or free-run.
// Revision : 1.0 - initial release
// ============================================================================
module jvo_pulse_seq #(
  parameter int N_CH  = 20,
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input  wire            clk,
  input  wire            rst,
  jvo_pulse_seq_if.slave bus
);

  localparam logic [1:0]       c_st_idle = 2'd0;
  localparam logic [1:0]       c_st_run  = 2'd1;
  localparam logic [1:0]       c_st_done = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W:0]   c_rep_one = {{REP_W{1'b0}}, 1'b1};

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_count;
  logic [N_CH-1:0]         r_io;
  logic [REP_W-1:0]        r_rep;
  logic                    r_upd_pend;
  logic                    r_tick;
  logic                    r_ack;

  logic [CNT_W-1:0]        r_sh_max;
  logic [N_CH*CNT_W-1:0]   r_sh_beg;
  logic [N_CH*CNT_W-1:0]   r_sh_end;
  logic [N_CH-1:0]         r_sh_init;

  logic                    w_go;
  logic                    w_wrap;
  logic                    w_last;
  logic                    w_reload;
  logic                    w_load_sh;
  logic [REP_W:0]          w_rep_next;
  logic [REP_W:0]          w_rep_tgt;
  logic [N_CH-1:0]         w_io_cmp;

  assign w_go       = bus.i_en & bus.i_run;
  assign w_wrap     = (r_count == r_sh_max);
  // One bit wider so the completed-period count never aliases before compare.
  assign w_rep_next = {1'b0, r_rep} + c_rep_one;
  assign w_rep_tgt  = (bus.i_rep_count == '0) ? c_rep_one : {1'b0, bus.i_rep_count};
  assign w_last     = bus.i_single & (w_rep_next >= w_rep_tgt);
  // An upd arriving on the wrap edge itself counts for that wrap.
  assign w_reload   = (r_state == c_st_run) & w_go & w_wrap & (r_upd_pend | bus.i_upd);
  // Shadows are transparent in IDLE and otherwise only change on a reload.
  assign w_load_sh  = (r_state == c_st_idle) | w_reload;

  // Per-channel compare: begin match asserts, end match deasserts, begin wins.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] w_beg;
    logic [CNT_W-1:0] w_end;
    assign w_beg       = r_sh_beg[g*CNT_W +: CNT_W];
    assign w_end       = r_sh_end[g*CNT_W +: CNT_W];
    assign w_io_cmp[g] = (r_count == w_beg) ? ~r_sh_init[g] :
                         (r_count == w_end) ?  r_sh_init[g] : r_io[g];
  end

  // Shadow settings register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_max  <= '0;
      r_sh_beg  <= '0;
      r_sh_end  <= '0;
      r_sh_init <= '0;
    end else if (w_load_sh) begin
      r_sh_max  <= bus.i_max_count;
      r_sh_beg  <= bus.i_cnt_beg;
      r_sh_end  <= bus.i_cnt_end;
      r_sh_init <= bus.i_io_init;
    end
  end

  // Sequencer FSM with period counter, channel outputs and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_count    <= '0;
      r_io       <= '0;
      r_rep      <= '0;
      r_upd_pend <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_count    <= '0;
          r_io       <= '0;
          r_upd_pend <= 1'b0;
          if (w_go) begin
            r_state <= c_st_run;
            r_io    <= bus.i_io_init;
            r_rep   <= '0;
          end
        end
        c_st_run: begin
          if (!w_go) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_io       <= '0;
            r_upd_pend <= 1'b0;
          end else begin
            r_io <= w_io_cmp;
            if (bus.i_upd) begin
              r_upd_pend <= 1'b1;
            end
            if (w_wrap) begin
              r_count <= '0;
              r_tick  <= 1'b1;
              r_rep   <= w_rep_next[REP_W-1:0];
              if (w_reload) begin
                r_upd_pend <= 1'b0;
                r_ack      <= 1'b1;
              end
              // Final period of a single-shot run parks outputs at idle level.
              if (w_last) begin
                r_state <= c_st_done;
                r_io    <= r_sh_init;
              end
            end else begin
              r_count <= r_count + c_cnt_one;
            end
          end
        end
        c_st_done: begin
          r_count <= '0;
          r_io    <= r_sh_init;
          if (bus.i_upd) begin
            r_upd_pend <= 1'b1;
          end
          if (!w_go) begin
            r_state    <= c_st_idle;
            r_io       <= '0;
            r_upd_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_count <= '0;
          r_io    <= '0;
        end
      endcase
    end
  end

  assign bus.o_io          = r_io;
  assign bus.o_count       = r_count;
  assign bus.o_period_tick = r_tick;
  assign bus.o_busy        = (r_state == c_st_run);
  assign bus.o_done        = (r_state == c_st_done);
  assign bus.o_upd_ack     = r_ack;

endmodule
`default_nettype wire
